// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use interlock, branch/jump flush and
// dcache-miss freeze, with saturating stall/flush counters and a sticky miss timeout.
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rtaddr_i,
    input  logic [4:0]       ifid_rsaddr_i,
    input  logic [4:0]       ifid_rtaddr_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dcache_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int unsigned TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             err_q;

    logic load_use;
    logic load_use_eff;
    logic redirect;
    logic stall_inc;
    logic flush_inc;
    logic err_set;

    // Raw load-use hazard between the load in EX and the sources of ID
    always_comb begin
        load_use = idex_memread_i
                 && (idex_rtaddr_i != 5'd0)
                 && ((idex_rtaddr_i == ifid_rsaddr_i) || (idex_rtaddr_i == ifid_rtaddr_i));
        redirect = branch_taken_i || jump_i;
        // ID was held for one cycle already; the same hazard must not stall again
        load_use_eff = load_use && (state_q != ST_LDSTALL);
    end

    // Next-state and control outputs
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        err_set       = 1'b0;

        if (dcache_stall_i) begin
            freeze_o     = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            stall_inc    = 1'b1;
            state_d      = ST_MEMWAIT;
            case (state_q)
                ST_MEMWAIT: timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
                default:    timer_d = TMR_W'(1);
            endcase
            err_set = (timer_d == TMR_MAX);
        end else begin
            // RUN, LDSTALL and the MEMWAIT release cycle share the same decode
            case (state_q)
                ST_RUN, ST_LDSTALL, ST_MEMWAIT: begin
                    if (load_use_eff) begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_bubble_o = 1'b1;
                        stall_inc     = 1'b1;
                        state_d       = ST_LDSTALL;
                    end else begin
                        ifid_flush_o = redirect;
                        flush_inc    = redirect;
                        state_d      = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, timer, saturating counters and sticky error
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO    = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             memread;
    logic [4:0]       ex_rt, id_rs, id_rt;
    logic             br, jmp, dc;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, freeze, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .idex_memread_i (memread),
        .idex_rtaddr_i  (ex_rt),
        .ifid_rsaddr_i  (id_rs),
        .ifid_rtaddr_i  (id_rt),
        .branch_taken_i (br),
        .jump_i         (jmp),
        .dcache_stall_i (dc),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .freeze_o       (freeze),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .err_o          (err)
    );

    typedef struct {
        logic pc, ifw, fl, bub, frz, er;
        int   sc, fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: counts, miss-run length, and whether ID was just held
    int m_stall, m_flush, m_timer;
    bit m_err, m_in_mem, m_held;

    function automatic void model_reset();
        m_stall = 0; m_flush = 0; m_timer = 0;
        m_err = 0; m_in_mem = 0; m_held = 0;
    endfunction

    function automatic exp_t model_step(input bit upd, input logic mr, input logic [4:0] xrt,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic b, input logic j, input logic d);
        exp_t e;
        bit hazard;
        e.sc = m_stall; e.fc = m_flush; e.er = m_err;
        e.pc = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.frz = 0;
        hazard = mr && xrt != 0 && (xrt == rs || xrt == rt) && !m_held;
        if (d) begin
            e.frz = 1; e.pc = 0; e.ifw = 0;
            if (upd) begin
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                m_timer = m_in_mem ? ((m_timer < TO) ? m_timer + 1 : TO) : 1;
                if (m_timer == TO) m_err = 1;
                m_in_mem = 1; m_held = 0;
            end
        end else if (hazard) begin
            e.pc = 0; e.ifw = 0; e.bub = 1;
            if (upd) begin
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                m_in_mem = 0; m_held = 1;
            end
        end else begin
            e.fl = b | j;
            if (upd) begin
                if (b | j) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                m_in_mem = 0; m_held = 0;
            end
        end
        return e;
    endfunction

    // Drive one cycle of inputs (called at posedge+1), queue expectation, advance model
    task automatic step(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic b, input logic j, input logic d);
        memread = mr; ex_rt = xrt; id_rs = rs; id_rt = rt; br = b; jmp = j; dc = d;
        sb.push_back(model_step(1'b1, mr, xrt, rs, rt, b, j, d));
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; block must look like idle RUN throughout
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; br = 0; jmp = 0; dc = 0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            sb.push_back(model_step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation on every falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc_write",    int'(pc_write),    int'(e.pc));
            chk("ifid_write",  int'(ifid_write),  int'(e.ifw));
            chk("ifid_flush",  int'(ifid_flush),  int'(e.fl));
            chk("idex_bubble", int'(idex_bubble), int'(e.bub));
            chk("freeze",      int'(freeze),      int'(e.frz));
            chk("stall_cnt",   int'(stall_cnt),   e.sc);
            chk("flush_cnt",   int'(flush_cnt),   e.fc);
            chk("err",         int'(err),         int'(e.er));
        end
    end

    initial begin
        int dc_left;
        rst_n = 1'b0;
        memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; br = 0; jmp = 0; dc = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset(2);
        idle(); idle();

        // Load-use on rs, held two cycles; then the same with r0 as destination
        step(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // Load-use on rt, branch in the same cycle deferred to LDSTALL
        step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        idle();

        // Branch and jump together count one flush
        do_reset(1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        idle();

        // Ten-cycle miss with a branch arriving in cycle 3 and held to release
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 5'd0, 5'd0, i >= 2, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(); idle();

        // Timeout: six-cycle miss, sticky error, then reset in the middle of a miss
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        do_reset(1);
        idle(); idle();
        // Exactly TO-1 stall cycles must not set the error
        for (int i = 0; i < TO - 1; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(); idle();

        // Counter saturation: continuous hazard stalls every other cycle
        do_reset(1);
        for (int i = 0; i < 40; i++) step(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();

        // Random traffic with miss bursts and occasional resets
        do_reset(1);
        dc_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic d;
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 2));
                dc_left = 0;
            end
            if (dc_left == 0 && $urandom_range(0, 7) == 0) dc_left = $urandom_range(1, 7);
            d = (dc_left > 0);
            if (dc_left > 0) dc_left--;
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, d);
        end
        idle();

        @(negedge clk); #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
